// File: rtl/clock_pkg.sv
// Shared mode encodings and time-of-day limits for the timekeeper.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_SET_HOUR = 2'd1,
    MODE_SET_MIN  = 2'd2
  } clockMode_e;

  localparam logic [6:0] HOURS_PER_DAY      = 7'd24;
  localparam logic [6:0] MINUTES_PER_HOUR   = 7'd60;
  localparam logic [6:0] SECONDS_PER_MINUTE = 7'd60;

  // Modulo increment: returns 0 once value reaches limit-1.
  function automatic logic [6:0] wrapInc(input logic [6:0] value, input logic [6:0] limit);
    return (value == limit - 7'd1) ? 7'd0 : value + 7'd1;
  endfunction

endpackage

// File: rtl/key_edge_sync.sv
// Pushbutton conditioner: 2-flop synchronizer plus falling-edge detector,
// producing a registered one-cycle press pulse per key press.
module key_edge_sync (
  input  logic clock_i,
  input  logic resetN_i,
  input  logic keyN_i,
  output logic press_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic press_q;
  logic press_d;

  assign press_d = prev_q & ~sync2_q;

  // Flops reset to the released level so a quiet key never looks like a press.
  always_ff @(posedge clock_i or negedge resetN_i) begin
    if (!resetN_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      press_q <= 1'b0;
    end else begin
      sync1_q <= keyN_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/clock_timekeeper.sv
// 24-hour timekeeper with a prescaled seconds tick and a two-key
// set-mode FSM (RUN -> SET_HOUR -> SET_MIN -> RUN).
module clock_timekeeper
  import clock_pkg::*;
#(
  parameter int CLK_HZ = 50000000
) (
  input  logic       CLOCK_50,
  input  logic       RESETN,
  input  logic       ENABLE,
  input  logic       KEY_MODE_N,
  input  logic       KEY_INC_N,
  output logic [6:0] HOURS,
  output logic [6:0] MINUTES,
  output logic [6:0] SECONDS,
  output logic       SEC_TICK,
  output logic [1:0] MODE
);

  localparam int PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_HZ - 1);

  clockMode_e       mode_q;
  logic [PRE_W-1:0] prescaler_q;
  logic [PRE_W-1:0] prescaler_d;
  logic [6:0]       hours_q;
  logic [6:0]       minutes_q;
  logic [6:0]       seconds_q;
  logic [6:0]       hoursTick_d;
  logic [6:0]       minutesTick_d;
  logic [6:0]       secondsTick_d;
  logic             modePress;
  logic             incPress;
  logic             secTick;

  key_edge_sync modeKeySync (
    .clock_i  (CLOCK_50),
    .resetN_i (RESETN),
    .keyN_i   (KEY_MODE_N),
    .press_o  (modePress)
  );

  key_edge_sync incKeySync (
    .clock_i  (CLOCK_50),
    .resetN_i (RESETN),
    .keyN_i   (KEY_INC_N),
    .press_o  (incPress)
  );

  assign secTick = (mode_q == MODE_RUN) && ENABLE && (prescaler_q == PRE_MAX);

  // Next time of day after one elapsed second, with full carry chain.
  always_comb begin
    prescaler_d   = secTick ? '0 : prescaler_q + PRE_W'(1);
    secondsTick_d = wrapInc(seconds_q, SECONDS_PER_MINUTE);
    minutesTick_d = minutes_q;
    hoursTick_d   = hours_q;
    if (seconds_q == SECONDS_PER_MINUTE - 7'd1) begin
      minutesTick_d = wrapInc(minutes_q, MINUTES_PER_HOUR);
      if (minutes_q == MINUTES_PER_HOUR - 7'd1) begin
        hoursTick_d = wrapInc(hours_q, HOURS_PER_DAY);
      end
    end
  end

  // A mode press always wins over a coincident inc press; a tick in RUN
  // still lands on the same edge that leaves for SET_HOUR.
  always_ff @(posedge CLOCK_50 or negedge RESETN) begin
    if (!RESETN) begin
      mode_q      <= MODE_RUN;
      prescaler_q <= '0;
      hours_q     <= 7'd0;
      minutes_q   <= 7'd0;
      seconds_q   <= 7'd0;
    end else begin
      case (mode_q)
        MODE_RUN: begin
          if (ENABLE) begin
            prescaler_q <= prescaler_d;
          end
          if (secTick) begin
            seconds_q <= secondsTick_d;
            minutes_q <= minutesTick_d;
            hours_q   <= hoursTick_d;
          end
          if (modePress) begin
            mode_q <= MODE_SET_HOUR;
          end
        end
        MODE_SET_HOUR: begin
          if (modePress) begin
            mode_q <= MODE_SET_MIN;
          end else if (incPress) begin
            hours_q <= wrapInc(hours_q, HOURS_PER_DAY);
          end
        end
        MODE_SET_MIN: begin
          if (modePress) begin
            mode_q      <= MODE_RUN;
            seconds_q   <= 7'd0;
            prescaler_q <= '0;
          end else if (incPress) begin
            minutes_q <= wrapInc(minutes_q, MINUTES_PER_HOUR);
          end
        end
        default: begin
          mode_q <= MODE_RUN;
        end
      endcase
    end
  end

  assign HOURS    = hours_q;
  assign MINUTES  = minutes_q;
  assign SECONDS  = seconds_q;
  assign MODE     = mode_q;
  assign SEC_TICK = secTick;

endmodule

// File: tb/tb_clock_timekeeper.sv
// Scoreboard bench for clock_timekeeper at CLK_HZ=4: expectations are queued
// from a time-of-day model as stimulus is applied and drained against the DUT.
module tb_clock_timekeeper;

  localparam int CLK_HZ = 4;

  logic       CLOCK_50 = 1'b0;
  logic       RESETN = 1'b0;
  logic       ENABLE = 1'b0;
  logic       KEY_MODE_N = 1'b1;
  logic       KEY_INC_N = 1'b1;
  logic [6:0] HOURS;
  logic [6:0] MINUTES;
  logic [6:0] SECONDS;
  logic       SEC_TICK;
  logic [1:0] MODE;

  typedef struct {
    string tag;
    int    field;
    int    value;
  } expect_t;

  expect_t scoreboard[$];
  int totalChecks = 0;
  int badChecks = 0;
  int tickCount = 0;
  int tickBase;
  int modelH = 0;
  int modelM = 0;
  int modelS = 0;
  int modelMode = 0;

  clock_timekeeper #(.CLK_HZ(CLK_HZ)) dut (
    .CLOCK_50   (CLOCK_50),
    .RESETN     (RESETN),
    .ENABLE     (ENABLE),
    .KEY_MODE_N (KEY_MODE_N),
    .KEY_INC_N  (KEY_INC_N),
    .HOURS      (HOURS),
    .MINUTES    (MINUTES),
    .SECONDS    (SECONDS),
    .SEC_TICK   (SEC_TICK),
    .MODE       (MODE)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Ticks are counted mid-cycle, away from the active edge.
  always @(negedge CLOCK_50) begin
    if (SEC_TICK === 1'b1) tickCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    totalChecks++;
    if (actual !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0d want %0d", tag, actual, expected);
    end
  endtask

  function automatic logic [31:0] sampleField(input int field);
    case (field)
      0: return {25'd0, HOURS};
      1: return {25'd0, MINUTES};
      2: return {25'd0, SECONDS};
      3: return {30'd0, MODE};
      4: return {31'd0, SEC_TICK};
      default: return tickCount - tickBase;
    endcase
  endfunction

  task automatic expectField(input string tag, input int field, input int value);
    expect_t e;
    e.tag = tag;
    e.field = field;
    e.value = value;
    scoreboard.push_back(e);
  endtask

  task automatic expectModel(input string prefix);
    expectField({prefix, "_hours"}, 0, modelH);
    expectField({prefix, "_minutes"}, 1, modelM);
    expectField({prefix, "_seconds"}, 2, modelS);
    expectField({prefix, "_mode"}, 3, modelMode);
  endtask

  task automatic drainScoreboard();
    expect_t e;
    while (scoreboard.size() > 0) begin
      e = scoreboard.pop_front();
      checkOutput(e.tag, sampleField(e.field), e.value);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic modelReset();
    modelH = 0;
    modelM = 0;
    modelS = 0;
    modelMode = 0;
  endtask

  task automatic modelAdvance(input int secs);
    int total;
    total = (modelH * 3600 + modelM * 60 + modelS + secs) % 86400;
    modelH = total / 3600;
    modelM = (total / 60) % 60;
    modelS = total % 60;
  endtask

  // One press (and release) of the selected keys, mirrored in the model.
  task automatic applyStimulus(input bit modeKey, input bit incKey);
    KEY_MODE_N = ~modeKey;
    KEY_INC_N = ~incKey;
    waitCycles(5);
    KEY_MODE_N = 1'b1;
    KEY_INC_N = 1'b1;
    waitCycles(5);
    if (modeKey) begin
      case (modelMode)
        0: modelMode = 1;
        1: modelMode = 2;
        default: begin
          modelMode = 0;
          modelS = 0;
        end
      endcase
    end else if (incKey) begin
      if (modelMode == 1) modelH = (modelH + 1) % 24;
      else if (modelMode == 2) modelM = (modelM + 1) % 60;
    end
  endtask

  task automatic pressMany(input bit modeKey, input bit incKey, input int n);
    for (int i = 0; i < n; i++) applyStimulus(modeKey, incKey);
  endtask

  // Run cycles must be a multiple of CLK_HZ starting from prescaler 0.
  task automatic runEnabled(input int cycles);
    ENABLE = 1'b1;
    waitCycles(cycles);
    ENABLE = 1'b0;
    modelAdvance(cycles / CLK_HZ);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin
    #2;
    expectModel("por");
    expectField("por_tick", 4, 0);
    drainScoreboard();
    waitCycles(2);
    RESETN = 1'b1;
    waitCycles(1);

    ENABLE = 1'b1;
    waitCycles(6);
    expectField("midcount_seconds", 2, 1);
    drainScoreboard();
    RESETN = 1'b0;
    #1;
    modelReset();
    expectModel("async_reset");
    expectField("async_reset_tick", 4, 0);
    drainScoreboard();
    ENABLE = 1'b0;
    waitCycles(2);
    RESETN = 1'b1;
    waitCycles(1);

    tickBase = tickCount;
    runEnabled(240);
    expectModel("count240");
    expectField("count240_minutes_literal", 1, 1);
    expectField("count240_ticks", 5, 60);
    drainScoreboard();
    waitCycles(20);
    expectModel("frozen");
    expectField("frozen_ticks", 5, 60);
    drainScoreboard();

    runEnabled(8);
    expectField("pre_set_seconds", 2, 2);
    drainScoreboard();

    applyStimulus(1'b1, 1'b0);
    expectModel("enter_set_hour");
    drainScoreboard();
    pressMany(1'b0, 1'b1, 5);
    expectModel("hour_plus5");
    drainScoreboard();
    pressMany(1'b0, 1'b1, 24);
    expectField("hour_wrap24", 0, 5);
    drainScoreboard();
    pressMany(1'b0, 1'b1, 18);
    expectModel("hour_23");
    drainScoreboard();

    applyStimulus(1'b1, 1'b0);
    pressMany(1'b0, 1'b1, 58);
    expectModel("minute_59");
    drainScoreboard();
    applyStimulus(1'b0, 1'b1);
    expectField("minute_wrap", 1, 0);
    expectField("minute_wrap_hours", 0, 23);
    drainScoreboard();
    pressMany(1'b0, 1'b1, 59);
    applyStimulus(1'b1, 1'b0);
    expectModel("back_to_run");
    expectField("back_to_run_seconds_cleared", 2, 0);
    drainScoreboard();

    tickBase = tickCount;
    runEnabled(236);
    expectModel("pre_rollover");
    drainScoreboard();
    runEnabled(4);
    expectModel("rollover");
    expectField("rollover_ticks", 5, 60);
    drainScoreboard();

    applyStimulus(1'b0, 1'b1);
    expectModel("inc_ignored_run");
    drainScoreboard();

    applyStimulus(1'b1, 1'b0);
    pressMany(1'b0, 1'b1, 3);
    applyStimulus(1'b1, 1'b1);
    expectModel("collision");
    expectField("collision_mode", 3, 2);
    drainScoreboard();

    pressMany(1'b0, 1'b1, 37);
    expectModel("minute_37");
    drainScoreboard();
    KEY_INC_N = 1'b0;
    waitCycles(2);
    RESETN = 1'b0;
    #1;
    modelReset();
    expectModel("reset_mid_set");
    drainScoreboard();
    waitCycles(2);
    RESETN = 1'b1;
    waitCycles(8);
    KEY_INC_N = 1'b1;
    waitCycles(8);
    expectModel("after_held_reset");
    drainScoreboard();

    applyStimulus(1'b1, 1'b0);
    KEY_INC_N = 1'b0;
    waitCycles(30);
    KEY_INC_N = 1'b1;
    waitCycles(5);
    modelH = (modelH + 1) % 24;
    expectModel("held_single_press");
    drainScoreboard();

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
